// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with single-line refill over a req/ack memory port.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_EN.
//
// state  | meaning
// S_IDLE | lookup; a hit answers combinationally, a miss launches a refill
// S_FILL | waiting on mem_ack for the line at r_mem_addr; fetch is stalled
module icache_dm_refill #(
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic                             flush,
  output logic                             rsp_valid,
  output logic [WORD_W-1:0]                rsp_instr,
  output logic                             stall,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic                             mem_ack,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
`endif
);

  localparam int WB    = $clog2(WORD_W / 8);
  localparam int OFF   = $clog2(WORD_W / 8 * WORDS_PER_LINE);
  localparam int IDXW  = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int TAGW  = ADDR_W - OFF - $clog2(LINES);
  localparam int WSELW = (OFF - WB > 0) ? OFF - WB : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_flush_pend;
  logic [LINES-1:0]  r_valid;
  logic [TAGW-1:0]   r_tag  [LINES];
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] r_data [LINES];

  logic [IDXW-1:0]  w_idx, w_fidx;
  logic [TAGW-1:0]  w_tag, w_ftag;
  logic [WSELW-1:0] w_wsel;
  logic             w_hit, w_miss;

  assign w_idx  = (LINES > 1) ? IDXW'(req_addr >> OFF) : '0;
  assign w_tag  = TAGW'(req_addr >> (OFF + $clog2(LINES)));
  assign w_wsel = (WORDS_PER_LINE > 1) ? WSELW'(req_addr >> WB) : '0;
  // Refill targets the latched line address, not the live request.
  assign w_fidx = (LINES > 1) ? IDXW'(r_mem_addr >> OFF) : '0;
  assign w_ftag = TAGW'(r_mem_addr >> (OFF + $clog2(LINES)));

  assign w_hit  = req_valid && r_valid[w_idx] && (r_tag[w_idx] == w_tag) && (r_state == S_IDLE);
  assign w_miss = req_valid && !w_hit && (r_state == S_IDLE);

  assign rsp_valid = w_hit;
  assign rsp_instr = w_hit ? r_data[w_idx][w_wsel] : '0;
  assign mem_addr  = r_mem_addr;

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    mem_req     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          stall       = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mem_addr   <= '0;
      r_flush_pend <= 1'b0;
      r_valid      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        if (flush) r_valid <= '0;
        if (w_miss) r_mem_addr <= req_addr & ~OFF_MASK;
      end else begin
        if (mem_ack) begin
          r_flush_pend <= 1'b0;
          // A flush seen during the refill also discards the line just installed.
          if (r_flush_pend || flush) r_valid <= '0;
          else r_valid[w_fidx] <= 1'b1;
        end else if (flush) begin
          r_flush_pend <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FILL && mem_ack) begin
      r_tag[w_fidx]  <= w_ftag;
      r_data[w_fidx] <= mem_rdata;
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit)  hit_count  <= hit_count + 32'd1;
      if (w_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed self-checking bench for icache_dm_refill (default parameters).
// Counter checks are included when ICACHE_PERF_EN is defined.
module tb_icache_dm_refill;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic [15:0] rsp_instr;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] LINE0 = 64'h0003_0002_0001_0000;
  localparam logic [63:0] LINE1 = 64'h0007_0006_0005_0004;
  localparam logic [63:0] LINEC = 64'h000B_000A_0009_0008;
  localparam logic [63:0] LINE2 = 64'h00F3_00F2_00F1_00F0;
  localparam logic [63:0] LINE4 = 64'h0123_0122_0121_0120;

  icache_dm_refill dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a missing address, check the stall, then serve the refill.
  task automatic do_miss(input logic [15:0] addr, input logic [15:0] line_addr,
                         input logic [63:0] line);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    check("miss_stall", stall, 1);
    check("miss_rspv", rsp_valid, 0);
    check("miss_noreq", mem_req, 0);
    step();
    check("fill_req", mem_req, 1);
    check("fill_addr", mem_addr, line_addr);
    check("fill_stall", stall, 1);
    mem_ack   = 1'b1;
    mem_rdata = line;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_hit(input logic [15:0] addr, input logic [15:0] exp);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    check("hit_rspv", rsp_valid, 1);
    check("hit_instr", rsp_instr, exp);
    check("hit_nostall", stall, 0);
    check("hit_noreq", mem_req, 0);
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #3;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_stall", stall, 0);
    check("rst_rspv", rsp_valid, 0);
    check("rst_instr", rsp_instr, 0);
    step();
    rst_n = 1'b1;
    step();

    // 1: cold miss on line 0, then a hit per cycle across the line
    do_miss(16'h0000, 16'h0000, LINE0);
    do_hit(16'h0000, 16'h0000);
    do_hit(16'h0002, 16'h0001);
    do_hit(16'h0004, 16'h0002);
    do_hit(16'h0006, 16'h0003);
`ifdef ICACHE_PERF_EN
    check("perf_hits", hit_count, 4);
    check("perf_misses", miss_count, 1);
`endif

    // idle without request, stray ack ignored
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    #1;
    check("idle_rspv", rsp_valid, 0);
    check("idle_stall", stall, 0);
    check("idle_instr", rsp_instr, 0);
    step();
    mem_ack = 1'b0;
    #1;
    check("stray_ack_noreq", mem_req, 0);
    check("stray_ack_nostall", stall, 0);

    // 2: line 1, misaligned lookup rounds down
    do_miss(16'h000A, 16'h0008, LINE1);
    do_hit(16'h000A, 16'h0005);
    do_hit(16'h0003, 16'h0001);
    do_hit(16'h000E, 16'h0007);

    // 3: conflict on index 0 evicts line 0
    do_miss(16'h0040, 16'h0040, LINEC);
    do_hit(16'h0040, 16'h0008);
    do_hit(16'h0046, 16'h000B);
    do_miss(16'h0000, 16'h0000, LINE0);
    do_hit(16'h0002, 16'h0001);
    do_hit(16'h0008, 16'h0004);

    // 4: slow memory, ack withheld for 5 cycles
    req_valid = 1'b1;
    req_addr  = 16'h0014;
    #1;
    check("slow_miss_stall", stall, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      check("slow_stall", stall, 1);
      check("slow_req", mem_req, 1);
      check("slow_addr", mem_addr, 16'h0010);
      check("slow_rspv", rsp_valid, 0);
      step();
    end
    mem_ack   = 1'b1;
    mem_rdata = LINE2;
    step();
    mem_ack   = 1'b0;
    do_hit(16'h0014, 16'h00F2);

    // 5a: flush in IDLE; the same-cycle lookup still sees the old line
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'h0002;
    #1;
    check("flush_sameclk_rspv", rsp_valid, 1);
    check("flush_sameclk_instr", rsp_instr, 16'h0001);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    step();
    do_miss(16'h0002, 16'h0000, LINE0);
    do_hit(16'h0002, 16'h0001);
    req_valid = 1'b1;
    req_addr  = 16'h0014;
    #1;
    check("flush_all_lines", rsp_valid, 0);
    req_valid = 1'b0;
    step();

    // 5b: flush during FILL discards the refilled line
    req_valid = 1'b1;
    req_addr  = 16'h0020;
    step();
    check("pflush_req", mem_req, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("pflush_still_req", mem_req, 1);
    mem_ack   = 1'b1;
    mem_rdata = LINE4;
    step();
    mem_ack = 1'b0;
    check("pflush_rerequest_miss", stall, 1);
    check("pflush_rerequest_rspv", rsp_valid, 0);
    step();
    check("pflush_refill_addr", mem_addr, 16'h0020);
    mem_ack   = 1'b1;
    mem_rdata = LINE4;
    step();
    mem_ack = 1'b0;
    do_hit(16'h0022, 16'h0121);

    // 6: async reset in the middle of a refill
    req_valid = 1'b1;
    req_addr  = 16'h0030;
    step();
    check("rstfill_req", mem_req, 1);
    #2;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rstfill_mem_req", mem_req, 0);
    check("rstfill_stall", stall, 0);
    check("rstfill_rspv", rsp_valid, 0);
    check("rstfill_mem_addr", mem_addr, 0);
    step();
    rst_n = 1'b1;
    step();
    req_valid = 1'b1;
    req_addr  = 16'h0000;
    #1;
    check("post_rst_miss", stall, 1);
    check("post_rst_rspv", rsp_valid, 0);
    step();
    check("post_rst_fill_addr", mem_addr, 16'h0000);
`ifdef ICACHE_PERF_EN
    check("perf_rst_hits", hit_count, 0);
    check("perf_rst_misses", miss_count, 1);
`endif
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = LINE0;
    step();
    mem_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
